multi_voice_player: RTL and testbench

Multi-voice, fractional-rate sample-index generator: the next generation of the single-voice player. Each of NUM_VOICES voices has its own phase accumulator, step (pitch), loop/one-shot mode and start/stop control. Commands arrive over a valid/ready port. Per-voice clip read indices are produced once per sample period, which is derived from mclk by an internal prescaler. The block sits between the control front-end and the clip memories and mixer, which consume `voice_index` on `sample_valid`.

---
 rtl/multi_voice_player.sv | 147 ++++++++++++++
 tb/tb_multi_voice_player.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_voice_player.sv
// Multi-voice fractional-rate clip index generator with a valid/ready command port.
// Define PLAYER_DONE_IRQ_EN to enable the sticky one-shot done interrupt.
module multi_voice_player #(
    parameter int unsigned CLIP_LEN      = 8,
    parameter int unsigned FREQ_RES_BITS = 16,
    parameter int unsigned FRAC_BITS     = 8,
    parameter int unsigned NUM_VOICES    = 4,
    parameter int unsigned FREQ_PRESCALE = 256,
    localparam int unsigned IDX_W        = $clog2(CLIP_LEN),
    localparam int unsigned VW           = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                        mclk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [VW-1:0]               cmd_voice,
    input  logic [FREQ_RES_BITS-1:0]    cmd_step,
    input  logic                        cmd_loop,
    output logic                        sample_valid,
    output logic [NUM_VOICES*IDX_W-1:0] voice_index,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES-1:0]       voice_done,
    output logic                        irq
);

    localparam int unsigned PW  = IDX_W + FRAC_BITS;
    localparam int unsigned SW  = PW + 1;
    localparam int unsigned CW  = (FREQ_RES_BITS > SW) ? FREQ_RES_BITS : SW;
    localparam int unsigned PCW = $clog2(FREQ_PRESCALE);

    localparam logic [SW-1:0]  LIM      = SW'(CLIP_LEN) << FRAC_BITS;
    localparam logic [CW-1:0]  STEP_MAX = CW'(LIM) - CW'(1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(FREQ_PRESCALE - 1);

    typedef enum logic [1:0] {OpSetStep, OpStart, OpStop, OpClearIrq} cmd_op_e;

    logic [PCW-1:0]                 pc_q, pc_d;
    logic                           ready_q, ready_d;
    logic                           sv_q, sv_d;
    logic                           irq_q, irq_d;
    logic [NUM_VOICES-1:0]          done_q, done_d;
    logic [NUM_VOICES-1:0]          loop_q, loop_d;
    logic [NUM_VOICES-1:0]          active_q, active_d;
    logic [NUM_VOICES-1:0][PW-1:0]  phase_q, phase_d;
    logic [NUM_VOICES-1:0][PW-1:0]  step_q, step_d;
    logic [NUM_VOICES-1:0][SW-1:0]  sum;
    logic                           tick;
    logic                           cmd_fire;
    logic [CW-1:0]                  cmd_step_ext;
    logic [PW-1:0]                  step_new;

    always_comb begin
        tick         = (pc_q == PC_LAST);
        pc_d         = tick ? '0 : pc_q + 1'b1;
        ready_d      = (pc_d != PC_LAST);
        sv_d         = tick;
        cmd_fire     = cmd_valid && ready_q;
        cmd_step_ext = CW'(cmd_step);
        step_new     = (cmd_step_ext > STEP_MAX) ? STEP_MAX[PW-1:0] : cmd_step_ext[PW-1:0];

        phase_d  = phase_q;
        step_d   = step_q;
        loop_d   = loop_q;
        active_d = active_q;
        done_d   = '0;
        sum      = '0;

        // Ticks and accepted commands never share a cycle, so their order here is irrelevant.
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum[v] = {1'b0, phase_q[v]} + {1'b0, step_q[v]};
            if (tick && active_q[v]) begin
                if (sum[v] < LIM) begin
                    phase_d[v] = sum[v][PW-1:0];
                end else if (loop_q[v]) begin
                    phase_d[v] = PW'(sum[v] - LIM);
                end else begin
                    phase_d[v]  = '0;
                    active_d[v] = 1'b0;
                    done_d[v]   = 1'b1;
                end
            end
            if (cmd_fire && (cmd_voice == VW'(v))) begin
                case (cmd_op_e'(cmd_op))
                    OpSetStep: begin
                        step_d[v] = step_new;
                        loop_d[v] = cmd_loop;
                    end
                    OpStart: begin
                        phase_d[v]  = '0;
                        active_d[v] = 1'b1;
                    end
                    OpStop: begin
                        phase_d[v]  = '0;
                        active_d[v] = 1'b0;
                    end
                    OpClearIrq: ;
                endcase
            end
        end

`ifdef PLAYER_DONE_IRQ_EN
        // A done in the same cycle as a clear keeps the interrupt set.
        irq_d = (|done_d) | (irq_q & ~(cmd_fire && (cmd_op_e'(cmd_op) == OpClearIrq)));
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            ready_q  <= 1'b0;
            sv_q     <= 1'b0;
            irq_q    <= 1'b0;
            done_q   <= '0;
            loop_q   <= '0;
            active_q <= '0;
            phase_q  <= '0;
            step_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            ready_q  <= ready_d;
            sv_q     <= sv_d;
            irq_q    <= irq_d;
            done_q   <= done_d;
            loop_q   <= loop_d;
            active_q <= active_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        voice_index = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_index[v*IDX_W +: IDX_W] = phase_q[v][PW-1:FRAC_BITS];
        end
    end

    assign cmd_ready    = ready_q;
    assign sample_valid = sv_q;
    assign voice_active = active_q;
    assign voice_done   = done_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_multi_voice_player.sv
// Bench for multi_voice_player: directed vector tables plus randomized commands checked
// cycle by cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_multi_voice_player;

    localparam int unsigned CLIP_LEN  = 8;
    localparam int unsigned FRB       = 16;
    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned NV        = 3;
    localparam int unsigned P         = 256;
    localparam int unsigned IW        = 3;
    localparam int unsigned VW        = 2;
    localparam int          LIM       = CLIP_LEN << FRAC_BITS;
`ifdef PLAYER_DONE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [1:0] OP_SET = 2'd0, OP_START = 2'd1, OP_STOP = 2'd2, OP_CLR = 2'd3;

    logic              mclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [VW-1:0]     cmd_voice = '0;
    logic [FRB-1:0]    cmd_step = '0;
    logic              cmd_loop = 1'b0;
    logic              sample_valid;
    logic [NV*IW-1:0]  voice_index;
    logic [NV-1:0]     voice_active;
    logic [NV-1:0]     voice_done;
    logic              irq;

    multi_voice_player #(
        .CLIP_LEN     (CLIP_LEN),
        .FREQ_RES_BITS(FRB),
        .FRAC_BITS    (FRAC_BITS),
        .NUM_VOICES   (NV),
        .FREQ_PRESCALE(P)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_voice   (cmd_voice),
        .cmd_step    (cmd_step),
        .cmd_loop    (cmd_loop),
        .sample_valid(sample_valid),
        .voice_index (voice_index),
        .voice_active(voice_active),
        .voice_done  (voice_done),
        .irq         (irq)
    );

    always #5 mclk = ~mclk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phases in fractional units, plain integer arithmetic.
    int m_pc;
    bit m_ready, m_sv, m_irq, m_tick, m_fire;
    int m_phase[NV], m_step[NV], m_sum;
    bit m_loop[NV], m_act[NV], m_done[NV];

    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_ready = 0; m_sv = 0; m_irq = 0;
            for (int v = 0; v < NV; v++) begin
                m_phase[v] = 0; m_step[v] = 0; m_loop[v] = 0; m_act[v] = 0; m_done[v] = 0;
            end
        end else begin
            m_tick = (m_pc == P - 1);
            m_fire = cmd_valid && m_ready;
            m_sv   = m_tick;
            for (int v = 0; v < NV; v++) begin
                m_done[v] = 0;
                if (m_tick && m_act[v]) begin
                    m_sum = m_phase[v] + m_step[v];
                    if (m_sum < LIM) m_phase[v] = m_sum;
                    else if (m_loop[v]) m_phase[v] = m_sum - LIM;
                    else begin m_phase[v] = 0; m_act[v] = 0; m_done[v] = 1; end
                end
            end
            if (m_fire && int'(cmd_voice) < NV) begin
                case (cmd_op)
                    OP_SET: begin
                        m_step[int'(cmd_voice)] = (int'(cmd_step) > LIM - 1) ? LIM - 1 : int'(cmd_step);
                        m_loop[int'(cmd_voice)] = cmd_loop;
                    end
                    OP_START: begin m_phase[int'(cmd_voice)] = 0; m_act[int'(cmd_voice)] = 1; end
                    OP_STOP:  begin m_phase[int'(cmd_voice)] = 0; m_act[int'(cmd_voice)] = 0; end
                    default: ;
                endcase
            end
            if (m_fire && cmd_op == OP_CLR) m_irq = 0;
            for (int v = 0; v < NV; v++) if (IRQ_EN && m_done[v]) m_irq = 1;
            m_pc    = (m_pc + 1) % P;
            m_ready = (m_pc != P - 1);
        end
    end

    logic [NV*IW-1:0] e_idx;
    logic [NV-1:0]    e_act, e_done;
    always @(negedge mclk) begin
        if (chk_en && rst_n) begin
            for (int v = 0; v < NV; v++) begin
                e_idx[v*IW +: IW] = IW'(m_phase[v] >> FRAC_BITS);
                e_act[v]  = m_act[v];
                e_done[v] = m_done[v];
            end
            check("model_cycle",
                  32'({cmd_ready, sample_valid, irq, voice_done, voice_active, voice_index}),
                  32'({m_ready, m_sv, m_irq, e_done, e_act, e_idx}));
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input int v, input logic [FRB-1:0] st,
                            input logic lp);
        bit acc;
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_voice = VW'(v); cmd_step = st; cmd_loop = lp;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 4) begin
            acc = cmd_ready;
            @(posedge mclk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_sv(output int n);
        n = 0;
        do begin
            @(posedge mclk); #1;
            n++;
        end while (!sample_valid && n <= 2 * P);
        if (!sample_valid) begin
            n_tests++; n_fail++;
            $display("FAIL wait_sv: sample_valid absent after %0d cycles, required within %0d", n, P);
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        int            voice;
        logic [15:0]   step;
        logic          loop;
        logic [NV-1:0] exp_act;
    } cmd_vec_t;

    typedef struct {
        logic [IW-1:0] i0, i1, i2;
        logic [NV-1:0] act;
        logic [NV-1:0] done;
        logic          irq_if_en;
    } pulse_vec_t;

    cmd_vec_t   cmds[9];
    pulse_vec_t pulses[9];

    initial begin
        int n;
        logic [1:0]     rop;
        logic [FRB-1:0] rstep;
        int             rsel;

        // Voice 2 gets an oversize step: clamped to 0x7FF it loops one fractional unit backwards.
        cmds[0] = '{OP_SET,   0, 16'h0100, 1'b1, 3'b000};
        cmds[1] = '{OP_START, 0, 16'h0000, 1'b0, 3'b001};
        cmds[2] = '{OP_SET,   1, 16'h0180, 1'b0, 3'b001};
        cmds[3] = '{OP_START, 1, 16'h0000, 1'b0, 3'b011};
        cmds[4] = '{OP_SET,   2, 16'h1A00, 1'b1, 3'b011};
        cmds[5] = '{OP_START, 2, 16'h0000, 1'b0, 3'b111};
        cmds[6] = '{OP_SET,   3, 16'h0300, 1'b0, 3'b111};
        cmds[7] = '{OP_START, 3, 16'h0000, 1'b0, 3'b111};
        cmds[8] = '{OP_STOP,  3, 16'h0000, 1'b0, 3'b111};

        pulses[0] = '{3'd1, 3'd1, 3'd7, 3'b111, 3'b000, 1'b0};
        pulses[1] = '{3'd2, 3'd3, 3'd7, 3'b111, 3'b000, 1'b0};
        pulses[2] = '{3'd3, 3'd4, 3'd7, 3'b111, 3'b000, 1'b0};
        pulses[3] = '{3'd4, 3'd6, 3'd7, 3'b111, 3'b000, 1'b0};
        pulses[4] = '{3'd5, 3'd7, 3'd7, 3'b111, 3'b000, 1'b0};
        pulses[5] = '{3'd6, 3'd0, 3'd7, 3'b101, 3'b010, 1'b1};
        pulses[6] = '{3'd7, 3'd0, 3'd7, 3'b101, 3'b000, 1'b1};
        pulses[7] = '{3'd0, 3'd0, 3'd7, 3'b101, 3'b000, 1'b1};
        pulses[8] = '{3'd1, 3'd0, 3'd7, 3'b101, 3'b000, 1'b1};

        // Reset release and idle prescaler.
        chk_en = 1'b1;
        repeat (3) @(posedge mclk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_first_edge", 32'(cmd_ready), 32'(0));
        @(posedge mclk); #1;
        check("ready_after_first_edge", 32'(cmd_ready), 32'(1));
        wait_sv(n);
        check("first_tick_latency", 32'(n + 1), 32'(P));
        check("idle_index", 32'(voice_index), 32'(0));
        check("idle_active", 32'(voice_active), 32'(0));
        wait_sv(n);
        check("sample_period", 32'(n), 32'(P));

        // Command table applied early in one sample period.
        for (int i = 0; i < 9; i++) begin
            send_cmd(cmds[i].op, cmds[i].voice, cmds[i].step, cmds[i].loop);
            check($sformatf("cmd%0d_active", i), 32'(voice_active), 32'(cmds[i].exp_act));
            check($sformatf("cmd%0d_index", i), 32'(voice_index), 32'(0));
        end
        for (int k = 0; k < 9; k++) begin
            wait_sv(n);
            check($sformatf("pulse%0d_index", k + 1), 32'(voice_index),
                  32'({pulses[k].i2, pulses[k].i1, pulses[k].i0}));
            check($sformatf("pulse%0d_active", k + 1), 32'(voice_active), 32'(pulses[k].act));
            check($sformatf("pulse%0d_done", k + 1), 32'(voice_done), 32'(pulses[k].done));
            check($sformatf("pulse%0d_irq", k + 1), 32'(irq), 32'(pulses[k].irq_if_en & IRQ_EN));
        end
        send_cmd(OP_CLR, 0, '0, 1'b0);
        check("irq_cleared", 32'(irq), 32'(0));

        // Command held across the tick cycle.
        wait_sv(n);
        repeat (P - 1) @(posedge mclk);
        #1 check("ready_low_on_tick", 32'(cmd_ready), 32'(0));
        cmd_valid = 1'b1; cmd_op = OP_START; cmd_voice = 2'd2; cmd_step = '0; cmd_loop = 1'b0;
        @(posedge mclk); #1;
        check("tick_sv_with_pending_cmd", 32'(sample_valid), 32'(1));
        check("ready_after_tick", 32'(cmd_ready), 32'(1));
        check("v2_not_restarted_on_tick", 32'(voice_index[2*IW +: IW]), 32'(7));
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
        check("v2_restarted_after_tick", 32'(voice_index[2*IW +: IW]), 32'(0));
        check("active_after_restart", 32'(voice_active), 32'(3'b101));

        // Randomized commands; the model check runs on every cycle.
        for (int it = 0; it < 60; it++) begin
            rsel = $urandom_range(0, 9);
            rop  = (rsel < 4) ? OP_SET : (rsel < 7) ? OP_START : (rsel < 9) ? OP_STOP : OP_CLR;
            case ($urandom_range(0, 3))
                0:       rstep = FRB'($urandom);
                1:       rstep = '0;
                default: rstep = FRB'($urandom_range(16'h40, 16'h600));
            endcase
            send_cmd(rop, int'($urandom_range(0, 3)), rstep, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 500)) @(posedge mclk);
            #1;
        end
        send_cmd(OP_SET, 0, 16'hFFFF, 1'b1);
        send_cmd(OP_START, 0, '0, 1'b0);
        repeat (3) wait_sv(n);

        // Reset in the middle of playback with irq set.
        send_cmd(OP_SET, 2, 16'h07FF, 1'b0);
        send_cmd(OP_START, 2, '0, 1'b0);
        wait_sv(n);
        wait_sv(n);
        check("v2_oneshot_done", 32'(voice_done[2]), 32'(1));
        check("irq_set_on_done", 32'(irq), 32'(IRQ_EN));
        for (int v = 0; v < NV; v++) begin
            send_cmd(OP_SET, v, 16'h0100, 1'b1);
            send_cmd(OP_START, v, '0, 1'b0);
        end
        wait_sv(n);
        repeat (50) @(posedge mclk);
        #1 check("three_active", 32'(voice_active), 32'(3'b111));
        #2 chk_en = 1'b0;
        rst_n = 1'b0;
        #1 check("outputs_zero_in_reset",
                 32'({cmd_ready, sample_valid, irq, voice_done, voice_active, voice_index}), 32'(0));
        @(posedge mclk); #1;
        check("outputs_zero_held_reset",
              32'({cmd_ready, sample_valid, irq, voice_done, voice_active, voice_index}), 32'(0));
        #3 rst_n = 1'b1;
        chk_en = 1'b1;
        wait_sv(n);
        check("tick_latency_after_reset", 32'(n), 32'(P));
        wait_sv(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
